// File: rtl/qnt_pkg.sv
// qnt_pkg: shared sizes and types for the AccLen builder and the bit-location finder
package qnt_pkg;
    localparam int MaximumNumberOfWord      = 32;
    localparam int MaximumNumberOfWordWidth = 9;
    localparam int BitLocationWidth         = 10;
    localparam int WordBitWidthWidth        = 6;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} acc_len_state_e;
    typedef logic [BitLocationWidth-1:0] bit_loc_t;
endpackage

// File: rtl/acc_len_builder.sv
// acc_len_builder: builds the saturating AccLen prefix-sum table and QntStructBits total
// Ports: Clk/Rst (sync, active-high); Start+NumWord begin a build; WordValid/WordBitWidth/WordReady
// stream the per-word widths; AccLen is the packed table (slot i at bits [(i+1)*BLW-1:i*BLW]);
// QntStructBits, AccLenValid, Overflow (sticky) and CfgError (illegal NumWord) report the result.
module acc_len_builder
    import qnt_pkg::*;
(
    input  logic                                          Clk,
    input  logic                                          Rst,
    input  logic                                          Start,
    input  logic [MaximumNumberOfWordWidth-1:0]           NumWord,
    input  logic                                          WordValid,
    input  logic [WordBitWidthWidth-1:0]                  WordBitWidth,
    output logic                                          WordReady,
    output logic [MaximumNumberOfWord*BitLocationWidth-1:0] AccLen,
    output logic [BitLocationWidth-1:0]                   QntStructBits,
    output logic                                          AccLenValid,
    output logic                                          Overflow,
    output logic                                          CfgError
);
    localparam int AccW = BitLocationWidth + 1;
    localparam int CntW = MaximumNumberOfWordWidth;

    acc_len_state_e state_q, state_d;
    logic [CntW-1:0] num_q, num_d, cnt_q, cnt_d;
    bit_loc_t        sum_q, sum_d, qsb_q, qsb_d, sum_sat;
    bit_loc_t        acc_q [MaximumNumberOfWord];
    bit_loc_t        acc_d [MaximumNumberOfWord];
    logic            valid_q, valid_d, ovf_q, ovf_d, cfg_q, cfg_d;
    logic [AccW-1:0] sum_nx;
    logic            illegal, xfer;

    assign WordReady = (state_q == LOAD) && !Start;
    assign xfer      = WordValid && WordReady;
    assign illegal   = (NumWord == '0) || (NumWord > CntW'(MaximumNumberOfWord));
    // one extra accumulator bit catches the carry that signals saturation
    assign sum_nx    = {1'b0, sum_q} + AccW'(WordBitWidth);
    assign sum_sat   = sum_nx[BitLocationWidth] ? '1 : sum_nx[BitLocationWidth-1:0];

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        qsb_d   = qsb_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        cfg_d   = cfg_q;
        acc_d   = acc_q;
        if (Start) begin
            state_d = illegal ? DONE : LOAD;
            num_d   = NumWord;
            cnt_d   = '0;
            sum_d   = '0;
            qsb_d   = '0;
            valid_d = illegal;
            ovf_d   = 1'b0;
            cfg_d   = illegal;
            for (int i = 0; i < MaximumNumberOfWord; i++) acc_d[i] = '0;
        end else if (xfer) begin
            sum_d = sum_sat;
            ovf_d = ovf_q | sum_nx[BitLocationWidth];
            cnt_d = cnt_q + CntW'(1);
            // decoded per-slot write keeps the table layout fixed
            for (int i = 0; i < MaximumNumberOfWord; i++)
                if (cnt_q == CntW'(i)) acc_d[i] = sum_sat;
            if (cnt_q == num_q - CntW'(1)) begin
                state_d = DONE;
                qsb_d   = sum_sat;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            qsb_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cfg_q   <= 1'b0;
            acc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            qsb_q   <= qsb_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            cfg_q   <= cfg_d;
            acc_q   <= acc_d;
        end
    end

    genvar g;
    for (g = 0; g < MaximumNumberOfWord; g++) begin : g_slot
        assign AccLen[g*BitLocationWidth +: BitLocationWidth] = acc_q[g];
    end

    assign QntStructBits = qsb_q;
    assign AccLenValid   = valid_q;
    assign Overflow      = ovf_q;
    assign CfgError      = cfg_q;
endmodule

// File: tb/tb_acc_len_builder.sv
// tb_acc_len_builder: random and directed builds checked against a prefix-sum model
module tb_acc_len_builder;
    import qnt_pkg::*;
    localparam int BLW  = BitLocationWidth;
    localparam int N    = MaximumNumberOfWord;
    localparam int MAXV = (1 << BLW) - 1;

    logic Clk = 1'b0;
    logic Rst, Start, WordValid, WordReady, AccLenValid, Overflow, CfgError;
    logic [MaximumNumberOfWordWidth-1:0] NumWord;
    logic [WordBitWidthWidth-1:0] WordBitWidth;
    logic [N*BLW-1:0] AccLen;
    logic [BLW-1:0] QntStructBits;

    int total = 0;
    int bad = 0;
    bit armed = 0;
    bit m_loading = 0, m_valid = 0, m_cfg = 0;
    int m_num = 0;
    int m_w[$];

    acc_len_builder dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .NumWord(NumWord),
        .WordValid(WordValid), .WordBitWidth(WordBitWidth), .WordReady(WordReady),
        .AccLen(AccLen), .QntStructBits(QntStructBits), .AccLenValid(AccLenValid),
        .Overflow(Overflow), .CfgError(CfgError)
    );

    always #5 Clk = ~Clk;

    function automatic int raw_total();
        int s = 0;
        foreach (m_w[i]) s += m_w[i];
        return s;
    endfunction

    function automatic logic [N*BLW-1:0] exp_table();
        int s = 0;
        logic [N*BLW-1:0] t = '0;
        foreach (m_w[i]) begin
            s += m_w[i];
            t[i*BLW +: BLW] = BLW'(s > MAXV ? MAXV : s);
        end
        return t;
    endfunction

    function automatic int slot(input int i);
        return int'(AccLen[i*BLW +: BLW]);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int raw;
        logic [N*BLW-1:0] et;
        raw = raw_total();
        et = exp_table();
        chk("valid", 64'(AccLenValid), 64'(m_valid));
        chk("cfg", 64'(CfgError), 64'(m_cfg));
        chk("ovf", 64'(Overflow), 64'(raw > MAXV));
        chk("qsb", 64'(QntStructBits), 64'((m_valid && !m_cfg) ? (raw > MAXV ? MAXV : raw) : 0));
        total++;
        if (AccLen !== et) begin
            bad++;
            $display("FAIL table: got %h want %h at %0t", AccLen, et, $time);
        end
    endtask

    task automatic cyc(input bit st, input int nw, input bit wv, input int wb, input bit rs);
        Rst = rs;
        Start = st;
        NumWord = MaximumNumberOfWordWidth'(nw);
        WordValid = wv;
        WordBitWidth = WordBitWidthWidth'(wb);
        #1;
        if (armed) chk("ready", 64'(WordReady), 64'(m_loading && !st));
        if (rs) begin
            m_loading = 0; m_valid = 0; m_cfg = 0; m_num = 0;
            m_w.delete();
        end else if (st) begin
            m_w.delete();
            m_num = nw;
            if (nw == 0 || nw > N) begin
                m_loading = 0; m_valid = 1; m_cfg = 1;
            end else begin
                m_loading = 1; m_valid = 0; m_cfg = 0;
            end
        end else if (m_loading && wv) begin
            m_w.push_back(wb);
            if (m_w.size() == m_num) begin
                m_loading = 0;
                m_valid = 1;
            end
        end
        @(posedge Clk);
        #1;
        check_all();
        armed = 1;
    endtask

    task automatic idle(); cyc(0, 0, 0, 0, 0); endtask
    task automatic word(input int w); cyc(0, 0, 1, w, 0); endtask
    task automatic start(input int n); cyc(1, n, 0, 0, 0); endtask

    initial begin
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // reset mid-LOAD
        start(4); word(9); word(9);
        cyc(0, 0, 1, 9, 1);
        cyc(0, 0, 1, 9, 1);
        chk("rst_valid", 64'(AccLenValid), 64'd0);
        chk("rst_table", 64'(AccLen == '0), 64'd1);
        chk("rst_qsb", 64'(QntStructBits), 64'd0);
        cyc(0, 0, 1, 5, 0);
        chk("rst_idle_ready", 64'(WordReady), 64'd0);
        // basic back-to-back build
        start(4); word(3); word(5); word(2);
        chk("basic_not_yet", 64'(AccLenValid), 64'd0);
        word(6);
        chk("basic_valid", 64'(AccLenValid), 64'd1);
        chk("basic_s0", 64'(slot(0)), 64'd3);
        chk("basic_s1", 64'(slot(1)), 64'd8);
        chk("basic_s2", 64'(slot(2)), 64'd10);
        chk("basic_s3", 64'(slot(3)), 64'd16);
        chk("basic_s4", 64'(slot(4)), 64'd0);
        chk("basic_qsb", 64'(QntStructBits), 64'd16);
        word(7); idle();
        // gapped input
        start(4);
        foreach (m_w[i]) ;
        cyc(0, 0, 0, 0, 0); word(3); cyc(0, 0, 0, 0, 0); word(5);
        cyc(0, 0, 0, 0, 0); word(2); cyc(0, 0, 0, 0, 0); word(6);
        chk("gap_valid", 64'(AccLenValid), 64'd1);
        chk("gap_s3", 64'(slot(3)), 64'd16);
        chk("gap_qsb", 64'(QntStructBits), 64'd16);
        // full table with saturation
        start(32);
        for (int i = 0; i < 32; i++) word(40);
        chk("sat_s24", 64'(slot(24)), 64'd1000);
        chk("sat_s25", 64'(slot(25)), 64'd1023);
        chk("sat_s31", 64'(slot(31)), 64'd1023);
        chk("sat_ovf", 64'(Overflow), 64'd1);
        chk("sat_qsb", 64'(QntStructBits), 64'd1023);
        // illegal NumWord
        start(0);
        chk("zero_cfg", 64'(CfgError), 64'd1);
        chk("zero_valid", 64'(AccLenValid), 64'd1);
        chk("zero_table", 64'(AccLen == '0), 64'd1);
        word(5); word(5);
        start(33);
        chk("big_cfg", 64'(CfgError), 64'd1);
        chk("big_valid", 64'(AccLenValid), 64'd1);
        word(5);
        // restart mid-LOAD
        start(4); word(9); word(9);
        start(2); word(7); word(1);
        chk("rs_s0", 64'(slot(0)), 64'd7);
        chk("rs_s1", 64'(slot(1)), 64'd8);
        chk("rs_s2", 64'(slot(2)), 64'd0);
        chk("rs_qsb", 64'(QntStructBits), 64'd8);
        chk("rs_ovf", 64'(Overflow), 64'd0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cyc(r >= 1 && r < 5, int'($urandom_range(0, 35)), $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 63)), r < 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
